// File: rtl/data_sram_resp_pkg.sv
// Shared constants and helpers for the data-SRAM responder: MMIO window base,
// register offsets and the byte-strobe to bit-mask expansion.
package dsram_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hBFAF_0000;

  localparam logic [15:0] OFF_TIMER   = 16'h0000;
  localparam logic [15:0] OFF_LED     = 16'h0004;
  localparam logic [15:0] OFF_SCRATCH = 16'h0008;
  localparam logic [15:0] OFF_RDCNT   = 16'h0010;
  localparam logic [15:0] OFF_WRCNT   = 16'h0014;

  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// CPU data-SRAM port: request fields from the memory stage, registered read data back.
interface data_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_resp_mmio.sv
// MMIO register block: timer, LED, scratch and (with DSRAM_ACCESS_CNT_EN) the
// saturating access counters. Read mux is combinational over pre-edge values.
module dsram_mmio
  import dsram_pkg::*;
#(
  parameter int LED_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [3:0]        we,
  input  logic [15:0]       off,
  input  logic [31:0]       wdata,
  input  logic              cnt_rd,
  input  logic              cnt_wr,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  led
);

  logic [31:0] timer;
  logic [31:0] scratch;
  logic [31:0] mask;
  logic [15:0] off_w;
  logic        sel_timer, sel_led, sel_scratch, sel_rdcnt, sel_wrcnt;
  logic [31:0] rdcnt_val, wrcnt_val;

  assign mask        = byte_mask(we);
  assign off_w       = {off[15:2], 2'b00};
  assign sel_timer   = (off_w == OFF_TIMER);
  assign sel_led     = (off_w == OFF_LED);
  assign sel_scratch = (off_w == OFF_SCRATCH);
  assign sel_rdcnt   = (off_w == OFF_RDCNT);
  assign sel_wrcnt   = (off_w == OFF_WRCNT);

  // A timer write takes priority over the free-running increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer   <= '0;
      scratch <= '0;
      led     <= '0;
    end else begin
      if (wr_en && sel_timer) timer <= (timer & ~mask) | (wdata & mask);
      else                    timer <= timer + 32'd1;
      if (wr_en && sel_scratch) scratch <= (scratch & ~mask) | (wdata & mask);
      if (wr_en && sel_led)
        led <= (led & ~mask[LED_W-1:0]) | (wdata[LED_W-1:0] & mask[LED_W-1:0]);
    end
  end

`ifdef DSRAM_ACCESS_CNT_EN
  logic [31:0] rdcnt, wrcnt;

  // Writing a counter clears it and swallows that cycle's own increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdcnt <= '0;
      wrcnt <= '0;
    end else begin
      if (wr_en && sel_rdcnt)               rdcnt <= '0;
      else if (cnt_rd && rdcnt != '1)       rdcnt <= rdcnt + 32'd1;
      if (wr_en && sel_wrcnt)               wrcnt <= '0;
      else if (cnt_wr && wrcnt != '1)       wrcnt <= wrcnt + 32'd1;
    end
  end

  assign rdcnt_val = rdcnt;
  assign wrcnt_val = wrcnt;
`else
  logic unused_cnt;
  assign unused_cnt = cnt_rd ^ cnt_wr;
  assign rdcnt_val  = '0;
  assign wrcnt_val  = '0;
`endif

  logic unused_off;
  assign unused_off = ^off[1:0];

  always_comb begin
    rdata = '0;
    if (sel_timer)   rdata = timer;
    if (sel_led)     rdata = {{(32-LED_W){1'b0}}, led};
    if (sel_scratch) rdata = scratch;
    if (sel_rdcnt)   rdata = rdcnt_val;
    if (sel_wrcnt)   rdata = wrcnt_val;
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: byte-strobed read-first RAM plus an MMIO window, one-cycle
// registered read data. Optional access counters enabled by DSRAM_ACCESS_CNT_EN.
module data_sram_resp
  import dsram_pkg::*;
#(
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter int          LED_W     = 16
) (
  input  logic              clk,
  input  logic              resetn,
  data_sram_resp_if.slave   bus,
  output logic [LED_W-1:0]  led
);

  logic [31:0]       ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic              mmio_hit;
  logic              is_wr;
  logic [31:0]       mmio_rdata;
  logic [31:0]       rdata_p1;

  assign ram_idx  = bus.data_sram_addr[RAM_AW+1:2];
  assign mmio_hit = (bus.data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign is_wr    = (bus.data_sram_we != 4'b0000);

  logic unused_addr;
  assign unused_addr = ^bus.data_sram_addr[1:0];

  dsram_mmio #(.LED_W(LED_W)) u_mmio (
    .clk    (clk),
    .resetn (resetn),
    .wr_en  (bus.data_sram_en && mmio_hit && is_wr),
    .we     (bus.data_sram_we),
    .off    (bus.data_sram_addr[15:0]),
    .wdata  (bus.data_sram_wdata),
    .cnt_rd (bus.data_sram_en && !is_wr),
    .cnt_wr (bus.data_sram_en && is_wr),
    .rdata  (mmio_rdata),
    .led    (led)
  );

  always_ff @(posedge clk) begin
    if (bus.data_sram_en && !mmio_hit) begin
      for (int i = 0; i < 4; i++)
        if (bus.data_sram_we[i]) ram[ram_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
    end
  end

  // ---- stage p1: registered response; writes return the pre-write word ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               rdata_p1 <= '0;
    else if (bus.data_sram_en) rdata_p1 <= mmio_hit ? mmio_rdata : ram[ram_idx];
  end

  assign bus.data_sram_rdata = rdata_p1;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp with a queue scoreboard; counter expectations
// follow DSRAM_ACCESS_CNT_EN.
module tb_data_sram_resp;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [15:0] led;

  data_sram_resp_if bus ();

  data_sram_resp dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .led    (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    string       n;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic chk_cur = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: response lands one edge after the flagged request cycle
  always @(posedge clk) begin
    if (chk_cur) begin
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scoreboard_empty: got response %08h expected none", bus.data_sram_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.n, bus.data_sram_rdata, e.v);
      end
    end
  end

  task automatic req(input logic en, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic chk, input logic [31:0] exp,
                     input string name);
    exp_t e;
    @(negedge clk);
    bus.data_sram_en    = en;
    bus.data_sram_we    = we;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    chk_cur = chk;
    if (chk) begin
      e.v = exp;
      e.n = name;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    req(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, "");
  endtask

  localparam logic [31:0] TMR = 32'hBFAF_0000;
  localparam logic [31:0] LEDA = 32'hBFAF_0004;
  localparam logic [31:0] SCR = 32'hBFAF_0008;
  localparam logic [31:0] RDC = 32'hBFAF_0010;
  localparam logic [31:0] WRC = 32'hBFAF_0014;

`ifdef DSRAM_ACCESS_CNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
    return CNT ? v : 32'h0;
  endfunction

  initial begin
    bus.data_sram_en    = 1'b0;
    bus.data_sram_we    = 4'h0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;
    #1;
    check("reset_rdata", bus.data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // 1. basic write/read, hold while idle, en=0 write suppressed
    req(1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678, 1'b0, 32'h0, "");
    req(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1, 32'h1234_5678, "ram_read");
    req(1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b1, 32'h1234_5678, "hold_idle");
    req(1'b0, 4'hF, 32'h0000_0100, 32'h0, 1'b1, 32'h1234_5678, "hold_en0_we");
    req(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1, 32'h1234_5678, "ram_no_en0_write");

    // 2. byte-strobed write, read-first response
    req(1'b1, 4'hF, 32'h0000_0200, 32'hAABB_CCDD, 1'b0, 32'h0, "");
    req(1'b1, 4'b0010, 32'h0000_0200, 32'h1111_1111, 1'b1, 32'hAABB_CCDD, "read_first");
    req(1'b1, 4'h0, 32'h0000_0200, 32'h0, 1'b1, 32'hAABB_11DD, "byte_strobe");

    // 3. address aliasing modulo RAM size
    req(1'b1, 4'hF, 32'h0001_0000, 32'hCAFE_F00D, 1'b0, 32'h0, "");
    req(1'b1, 4'h0, 32'h0000_0000, 32'h0, 1'b1, 32'hCAFE_F00D, "alias_word0");

    // 4. timer load and wrap, back-to-back reads
    req(1'b1, 4'hF, TMR, 32'hFFFF_FFFE, 1'b0, 32'h0, "");
    req(1'b1, 4'h0, TMR, 32'h0, 1'b1, 32'hFFFF_FFFE, "timer_n1");
    req(1'b1, 4'h0, TMR, 32'h0, 1'b1, 32'hFFFF_FFFF, "timer_n2");
    req(1'b1, 4'h0, TMR, 32'h0, 1'b1, 32'h0000_0000, "timer_wrap");

    // 5. LED, unmapped, en=0 guard, scratch, unmapped write
    req(1'b1, 4'b0011, LEDA, 32'hDEAD_BEEF, 1'b1, 32'h0, "led_write_old");
    req(1'b1, 4'h0, LEDA, 32'h0, 1'b1, 32'h0000_BEEF, "led_read");
    req(1'b1, 4'h0, 32'hBFAF_0020, 32'h0, 1'b1, 32'h0, "unmapped_read");
    #1 check("led_port", {16'h0, led}, 32'h0000_BEEF);
    req(1'b0, 4'hF, LEDA, 32'hFFFF_FFFF, 1'b1, 32'h0, "hold_after_unmapped");
    req(1'b1, 4'h0, LEDA, 32'h0, 1'b1, 32'h0000_BEEF, "led_en0_guard");
    req(1'b1, 4'b1100, SCR, 32'h1234_5678, 1'b1, 32'h0, "scratch_write_old");
    req(1'b1, 4'h0, SCR, 32'h0, 1'b1, 32'h1234_0000, "scratch_read");
    req(1'b1, 4'hF, 32'hBFAF_0020, 32'hFFFF_FFFF, 1'b1, 32'h0, "unmapped_write");

    // 6. access counters: 11 reads and 8 writes issued so far
    req(1'b1, 4'h0, RDC, 32'h0, 1'b1, cnt_exp(32'd11), "rdcnt");
    req(1'b1, 4'h0, WRC, 32'h0, 1'b1, cnt_exp(32'd8), "wrcnt");
    req(1'b1, 4'hF, WRC, 32'h5555_5555, 1'b1, cnt_exp(32'd8), "wrcnt_write_old");
    req(1'b1, 4'h0, WRC, 32'h0, 1'b1, cnt_exp(32'd0), "wrcnt_cleared");
    req(1'b1, 4'h0, RDC, 32'h0, 1'b1, cnt_exp(32'd14), "rdcnt_after");
    req(1'b1, 4'b0001, RDC, 32'h0, 1'b1, cnt_exp(32'd15), "rdcnt_write_old");
    req(1'b1, 4'h0, RDC, 32'h0, 1'b1, cnt_exp(32'd0), "rdcnt_cleared");
    req(1'b1, 4'h0, WRC, 32'h0, 1'b1, cnt_exp(32'd1), "wrcnt_one");
    idle();

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    idle();
    idle();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    // reset asserted in the middle of a request
    req(1'b1, 4'h0, SCR, 32'h0, 1'b0, 32'h0, "");
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midreset_rdata", bus.data_sram_rdata, 32'h0);
    check("midreset_led", {16'h0, led}, 32'h0);
    @(posedge clk);
    #1;
    check("midreset_hold", bus.data_sram_rdata, 32'h0);
    @(negedge clk);
    bus.data_sram_en = 1'b0;
    resetn = 1'b1;
    req(1'b1, 4'h0, SCR, 32'h0, 1'b1, 32'h0, "scratch_after_reset");
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
